// File: rtl/mul_pkg.sv
// Shared types and default widths for the multiplier write-back block.
package mul_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned REG_WIDTH  = 5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWrLo = 2'd1,
        StWrHi = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] lo;
        logic [DATA_WIDTH-1:0] hi;
        logic [REG_WIDTH-1:0]  r1;
        logic [REG_WIDTH-1:0]  r2;
    } entry_t;

endpackage

// File: rtl/mul_wb_fifo.sv
// Result queue for mul_wb: power-of-two depth, simultaneous push/pop legal even when full.
module mul_wb_fifo
    import mul_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mul_wb.sv
// Multiplier write-back: queues {lo,hi} results and writes them to the register file in two beats.
// Optional build macro MUL_WB_R0_DISCARD_EN skips writes addressed to register 0.
module mul_wb
    import mul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = mul_pkg::DATA_WIDTH,
    parameter int unsigned REG_WIDTH  = mul_pkg::REG_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_lo,
    input  logic [DATA_WIDTH-1:0] in_hi,
    input  logic [REG_WIDTH-1:0]  in_r1,
    input  logic [REG_WIDTH-1:0]  in_r2,
    output logic                  issue_ok,
    output logic                  wr_en,
    output logic [REG_WIDTH-1:0]  wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_ready,
    output logic                  busy,
    output logic                  overflow
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    state_e           state_q, state_d;
    entry_t           hold_q;
    entry_t           push_data;
    entry_t           pop_data;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] inflight_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             accept;
    logic             skip_lo;
    logic             skip_hi;
    logic             overflow_q;

    assign push_data = '{lo: in_lo, hi: in_hi, r1: in_r1, r2: in_r2};

    mul_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef MUL_WB_R0_DISCARD_EN
    assign skip_lo = (hold_q.r1 == '0);
    assign skip_hi = (hold_q.r2 == '0);
`else
    assign skip_lo = 1'b0;
    assign skip_hi = 1'b0;
`endif

    assign accept = wr_en && wr_ready;

    // State register and holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (pop) hold_q <= pop_data;
        end
    end

    // Next state; a skipped beat completes as though the register file accepted it.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StWrLo;
                end
            end
            StWrLo: begin
                if (accept || skip_lo) state_d = StWrHi;
            end
            StWrHi: begin
                if (accept || skip_hi) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = StWrLo;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Write-port outputs come straight from the holding register, so they stay put under stall.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        unique case (state_q)
            StWrLo: begin
                wr_en   = !skip_lo;
                wr_addr = hold_q.r1;
                wr_data = hold_q.lo;
            end
            StWrHi: begin
                wr_en   = !skip_hi;
                wr_addr = hold_q.r2;
                wr_data = hold_q.hi;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            case ({issue, in_valid})
                2'b10: if (inflight_q != CNT_W'(FIFO_DEPTH)) inflight_q <= inflight_q + CNT_W'(1);
                2'b01: if (inflight_q != '0) inflight_q <= inflight_q - CNT_W'(1);
                default: inflight_q <= inflight_q;
            endcase
            if (in_valid && fifo_full && !pop) overflow_q <= 1'b1;
        end
    end

    assign issue_ok = ({1'b0, fifo_count} + {1'b0, inflight_q}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign busy     = (state_q != StIdle) || !fifo_empty || (inflight_q != '0);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_mul_wb.sv
// Scoreboard bench for mul_wb: directed vectors push expected writes, a monitor checks accepted writes.
module tb_mul_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue;
    logic        in_valid;
    logic [31:0] in_lo;
    logic [31:0] in_hi;
    logic [4:0]  in_r1;
    logic [4:0]  in_r2;
    logic        issue_ok;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        busy;
    logic        overflow;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  acc_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    mul_wb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue    (issue),
        .in_valid (in_valid),
        .in_lo    (in_lo),
        .in_hi    (in_hi),
        .in_r1    (in_r1),
        .in_r2    (in_r2),
        .issue_ok (issue_ok),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: a write is accepted at the next rising edge when wr_en and wr_ready are both high.
    always @(negedge clk) begin
        if (rst_n && wr_en && wr_ready) begin
            wr_t e;
            checks++;
            acc_q.push_back(cyc + 1);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %h, none expected", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if (wr_addr !== e.a || wr_data !== e.d) begin
                    errors++;
                    $display("FAIL write_order: got addr %0d data %h, expected addr %0d data %h",
                             wr_addr, wr_data, e.a, e.d);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic pulse(input logic [31:0] lo, input logic [31:0] hi,
                         input logic [4:0] r1, input logic [4:0] r2);
        in_valid = 1'b1;
        in_lo    = lo;
        in_hi    = hi;
        in_r1    = r1;
        in_r2    = r2;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check({name, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int k;
        int n;
        rst_n    = 1'b0;
        issue    = 1'b0;
        in_valid = 1'b0;
        in_lo    = '0;
        in_hi    = '0;
        in_r1    = '0;
        in_r2    = '0;
        wr_ready = 1'b1;

        // Reset values.
        #12;
        check("rst_wr_en", {63'd0, wr_en}, 64'd0);
        check("rst_wr_addr", {59'd0, wr_addr}, 64'd0);
        check("rst_wr_data", {32'd0, wr_data}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_issue_ok", {63'd0, issue_ok}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single operation and latency.
        issue = 1'b1;
        tick();
        issue = 1'b0;
        check("single_busy_inflight", {63'd0, busy}, 64'd1);
        tick();
        tick();
        expect_wr(5'd3, 32'h11);
        expect_wr(5'd4, 32'h22);
        acc_q.delete();
        k = cyc + 1;
        pulse(32'h11, 32'h22, 5'd3, 5'd4);
        wait_idle("single");
        check("single_acc_count", 64'(acc_q.size()), 64'd2);
        check("single_lo_edge", 64'(acc_q[0]), 64'(k + 2));
        check("single_hi_edge", 64'(acc_q[1]), 64'(k + 3));

        // Backpressure during WR_LO.
        wr_ready = 1'b0;
        expect_wr(5'd9, 32'hAAAA5555);
        expect_wr(5'd10, 32'h1234);
        pulse(32'hAAAA5555, 32'h1234, 5'd9, 5'd10);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_stable", {26'd0, wr_en, wr_addr, wr_data}, {26'd0, 1'b1, 5'd9, 32'hAAAA5555});
            tick();
        end
        acc_q.delete();
        wr_ready = 1'b1;
        k = cyc + 1;
        wait_idle("bp");
        check("bp_lo_edge", 64'(acc_q[0]), 64'(k));
        check("bp_hi_edge", 64'(acc_q[1]), 64'(k + 1));

        // Credit limit: issue_ok drops after exactly FIFO_DEPTH issues.
        wr_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (!issue_ok) break;
            issue = 1'b1;
            tick();
            n++;
        end
        issue = 1'b0;
        check("credit_issues", 64'(n), 64'd4);
        check("credit_issue_ok_low", {63'd0, issue_ok}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            expect_wr(5'(10 + i), 32'h100 + 32'(i));
            expect_wr(5'(20 + i), 32'h200 + 32'(i));
            pulse(32'h100 + 32'(i), 32'h200 + 32'(i), 5'(10 + i), 5'(20 + i));
        end
        wr_ready = 1'b1;
        wait_idle("credit");
        check("credit_overflow", {63'd0, overflow}, 64'd0);
        check("credit_drained", 64'(exp_q.size()), 64'd0);
        check("credit_issue_ok_back", {63'd0, issue_ok}, 64'd1);

        // Overflow: the holding register absorbs the first entry, so the sixth back-to-back
        // pulse is the one that finds the queue full with no pop.
        wr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) begin
                expect_wr(5'(1 + i), 32'hA0 + 32'(i));
                expect_wr(5'(16 + i), 32'hB0 + 32'(i));
            end
            pulse(32'hA0 + 32'(i), 32'hB0 + 32'(i), 5'(1 + i), 5'(16 + i));
        end
        check("ovf_set", {63'd0, overflow}, 64'd1);
        wr_ready = 1'b1;
        wait_idle("ovf");
        check("ovf_sticky", {63'd0, overflow}, 64'd1);
        check("ovf_dropped", 64'(exp_q.size()), 64'd0);
        do_reset();
        check("ovf_cleared", {63'd0, overflow}, 64'd0);

        // Register 0 destination.
`ifndef MUL_WB_R0_DISCARD_EN
        expect_wr(5'd0, 32'hDEAD);
`endif
        expect_wr(5'd7, 32'hBEEF);
        pulse(32'hDEAD, 32'hBEEF, 5'd0, 5'd7);
        wait_idle("r0");
        check("r0_drained", 64'(exp_q.size()), 64'd0);

        // Reset while in WR_HI with another entry queued.
        wr_ready = 1'b0;
        pulse(32'h5151, 32'h5252, 5'd1, 5'd2);
        pulse(32'h6161, 32'h6262, 5'd5, 5'd6);
        expect_wr(5'd1, 32'h5151);
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        check("midhi_in_hi", {58'd0, wr_en, wr_addr}, {58'd0, 1'b1, 5'd2});
        #2;
        rst_n = 1'b0;
        #1;
        check("midhi_wr_en", {63'd0, wr_en}, 64'd0);
        check("midhi_busy", {63'd0, busy}, 64'd0);
        check("midhi_issue_ok", {63'd0, issue_ok}, 64'd1);
        @(negedge clk);
        rst_n    = 1'b1;
        wr_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("midhi_no_stale", {63'd0, busy}, 64'd0);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit in case a wait escapes its budget.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
